mips32_mem_arbiter: RTL and testbench
=====================================

# mips32_mem_arbiter

Single-clock arbiter that shares one single-port instruction/data memory between the MIPS32 pipeline's instruction-fetch (IF) port and data-memory (DM) port. Issues at most one memory access per cycle, using data-priority arbitration with a starvation guard for fetch. Tracks in-flight reads in a latency-matched tag pipe so each read response returns to the requester that issued it. Sits between the pipeline stages and the memory array, and honours the core's HALTED condition.

## Interface
- AW, 10, memory word-address width
- DW, 32, data width
- LAT, 2, memory read latency in cycles (legal 1..4)
- STARVE_MAX, 4, consecutive DM grants allowed while IF waits
- clk1  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- halted  in  1  core HALTED; blocks new IF grants only
- if_req  in  1  fetch request (read only)
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  DW  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data word address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_rvalid  out  1  load data valid (registered)
- dm_rdata  out  DW  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid LAT cycles after the issuing edge
- busy  out  1  any read in flight (registered)

## Operation
- Grant logic (combinational, one winner per cycle):
  - dm_gnt = dm_req and not force_if.
  - if_gnt = if_req and not halted and not dm_gnt.
  - force_if = (starve_cnt == STARVE_MAX) and if_req and not halted.
- mem_en = if_gnt or dm_gnt. mem_addr, mem_we and mem_wdata are muxed from the winner. An IF access always has mem_we = 0. When idle, mem_addr/mem_wdata are 0.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments on a DM grant while if_req and not halted.
  - Clears on an IF grant, or when if_req is low or halted is high.
  - Saturates at STARVE_MAX.
- Tag pipe: LAT stages of {valid, port}.
  - Stage 0 loads {mem_en and not mem_we, port}, where port 0 = IF and 1 = DM.
  - All stages shift every cycle.
  - When stage LAT-1 is valid, mem_rdata is registered into the matching rdata output and that port's rvalid is pulsed for one cycle.
- Stores produce no rvalid.
- rdata outputs hold their last value when rvalid is low.
- busy = OR of the tag-pipe valid bits.
- halted does not flush the pipe: reads already in flight still complete. DM traffic continues while halted.
- Ordering is strictly in issue order. A load issued after a store to the same address returns the stored data.

## Timing
- Request accepted in cycle T (gnt high); the memory samples at the T/T+1 edge.
- Read response: rvalid high in cycle T+LAT+1 exactly, for 1 cycle.
- Throughput is one access per cycle. Back-to-back reads from alternating ports return in issue order, each at +LAT+1.
- Simultaneous if_req and dm_req: DM wins, unless force_if is set, in which case IF wins and starve_cnt clears.
- Reset (sync, rst high at an edge):
  - Tag pipe valid bits, starve_cnt, rvalid, rdata and busy all go to 0.
  - Reads in flight at reset are discarded; no rvalid appears afterwards.
  - gnt and mem_en are forced to 0 while rst is high.
- A requester must hold req/addr/data stable until its gnt is seen. A deasserted req is simply dropped; there is no abort of granted accesses.

## Test plan
- Single fetch: LAT=2, mem[0]=0x280a00c8, if_req at cycle 5 addr 0 → if_gnt at 5, mem_en/addr 0 at 5, if_rvalid at cycle 8 with if_rdata 0x280a00c8, busy high cycles 6–7.
- Conflict: if_req and dm_req (load addr 200, mem[200]=7) both high in one cycle → dm_gnt=1, if_gnt=0; IF granted the next cycle; dm_rvalid data 7 arrives one cycle before if_rvalid.
- Starvation: STARVE_MAX=4, dm_req and if_req continuously high → pattern of 4 DM grants then 1 IF grant, repeating; no IF wait exceeds 4 cycles.
- Store then load: store 0x00000015 to addr 198 at cycle T, load 198 at T+1 → dm_rvalid at T+1+LAT+1 with data 0x15; no rvalid generated for the store.
- Halt: halted=1 with if_req high and a fetch already in flight → no new if_gnt, in-flight if_rvalid still delivered, DM loads still granted.
- Reset mid-flight: rst pulsed one cycle after a read grant → no rvalid at the expected cycle, busy=0 and starve_cnt=0 after reset, first post-reset request granted normally.

Source files
------------

// File: rtl/mips32_mem_arbiter_if.sv
// Request/response bundle between the pipeline's fetch (IF) and data (DM)
// ports and the shared-memory arbiter. Master = pipeline side, slave = arbiter.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Shares one single-port memory between fetch and data ports: data-priority
// grant with a fetch starvation guard, and a tag pipe that routes read data back.
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 halted,
  mips32_mem_arbiter_if.slave  bus,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]  starve_q, starve_d;
  logic           force_if, dm_win, if_win, if_gnt, dm_gnt;
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [LAT-1:0] tag_port_q, tag_port_d;
  logic           if_rvalid_q, dm_rvalid_q;
  logic [DW-1:0]  if_rdata_q, dm_rdata_q;
  logic           resp_vld, resp_dm;

  // Arbitration is computed unmasked first so reset can kill both grants.
  always_comb begin
    force_if = (starve_q == STARVE_LIM) && bus.if_req && !halted;
    dm_win   = bus.dm_req && !force_if;
    if_win   = bus.if_req && !halted && !dm_win;
    dm_gnt   = dm_win && !rst;
    if_gnt   = if_win && !rst;
  end

  assign bus.if_gnt = if_gnt;
  assign bus.dm_gnt = dm_gnt;

  always_comb begin
    mem_en    = if_gnt || dm_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_we    = bus.dm_we;
      mem_addr  = bus.dm_addr;
      mem_wdata = bus.dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = bus.if_addr;
    end
  end

  // Counts DM grants that overtook a waiting, unhalted fetch.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt || !bus.if_req || halted) begin
      starve_d = '0;
    end else if (dm_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  assign tag_vld_d[0]  = mem_en && !mem_we;
  assign tag_port_d[0] = dm_gnt;

  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
      assign tag_vld_d[gi]  = tag_vld_q[gi-1];
      assign tag_port_d[gi] = tag_port_q[gi-1];
    end
  endgenerate

  assign resp_vld = tag_vld_q[LAT-1];
  assign resp_dm  = tag_port_q[LAT-1];

  always_ff @(posedge clk1) begin
    if (rst) begin
      starve_q    <= '0;
      tag_vld_q   <= '0;
      tag_port_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      starve_q    <= starve_d;
      tag_vld_q   <= tag_vld_d;
      tag_port_q  <= tag_port_d;
      if_rvalid_q <= resp_vld && !resp_dm;
      dm_rvalid_q <= resp_vld && resp_dm;
      if (resp_vld && !resp_dm) begin
        if_rdata_q <= mem_rdata;
      end
      if (resp_vld && resp_dm) begin
        dm_rdata_q <= mem_rdata;
      end
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign busy          = |tag_vld_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Randomized scoreboard bench for mips32_mem_arbiter: a transaction-level
// predictor queues expected read responses, a monitor checks them as they appear.
module tb_mips32_mem_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int SM  = 4;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          halted = 1'b0;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(SM)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .halted    (halted),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 0) return 32'h280a00c8;
    if (i == 200) return 32'h00000007;
    return 32'(i) * 32'h9e3779b1;
  endfunction

  // Behavioural memory: word read sampled at the issuing edge, visible LAT cycles later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [LAT];
  always @(posedge clk1) begin
    if (cyc == 0) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    if (mem_en) rpipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q[$];

  // Predictor: the reference memory is updated in grant order.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int dm_streak = 0;
  logic e_force, e_dm, e_if;
  always @(negedge clk1) begin
    if (rst) begin
      chk("rst_if_gnt", 32'(bus.if_gnt), 32'(0));
      chk("rst_dm_gnt", 32'(bus.dm_gnt), 32'(0));
      chk("rst_mem_en", 32'(mem_en), 32'(0));
      dm_streak = 0;
    end else begin
      e_force = (dm_streak == SM) && bus.if_req && !halted;
      e_dm    = bus.dm_req && !e_force;
      e_if    = bus.if_req && !halted && !e_dm;
      chk("if_gnt", 32'(bus.if_gnt), 32'(e_if));
      chk("dm_gnt", 32'(bus.dm_gnt), 32'(e_dm));
      chk("mem_en", 32'(mem_en), 32'(e_if || e_dm));
      if (e_dm) begin
        chk("dm_mem_we", 32'(mem_we), 32'(bus.dm_we));
        chk("dm_mem_addr", 32'(mem_addr), 32'(bus.dm_addr));
        chk("dm_mem_wdata", mem_wdata, bus.dm_wdata);
        if (bus.dm_we) ref_mem[bus.dm_addr] = bus.dm_wdata;
        else q.push_back('{port: 1'b1, data: ref_mem[bus.dm_addr], due: cyc + LAT + 1});
      end else if (e_if) begin
        chk("if_mem_we", 32'(mem_we), 32'(0));
        chk("if_mem_addr", 32'(mem_addr), 32'(bus.if_addr));
        q.push_back('{port: 1'b0, data: ref_mem[bus.if_addr], due: cyc + LAT + 1});
      end else begin
        chk("idle_mem_addr", 32'(mem_addr), 32'(0));
        chk("idle_mem_wdata", mem_wdata, 32'(0));
      end
      if (!bus.if_req || halted || e_if) dm_streak = 0;
      else if (e_dm && dm_streak < SM) dm_streak++;
    end
  end

  // Monitor: pops expected responses when the DUT presents rvalid.
  bit armed = 1'b0;
  logic [DW-1:0] last_if = '0, last_dm = '0;
  int if_wait = 0;
  logic exp_busy;
  exp_t e;
  always @(negedge clk1) begin
    if (armed) begin
      exp_busy = 1'b0;
      foreach (q[i]) if (cyc >= q[i].due - LAT && cyc < q[i].due) exp_busy = 1'b1;
      chk("busy", 32'(busy), 32'(exp_busy));
      if (bus.if_rvalid && bus.dm_rvalid) begin
        total++; bad++;
        $display("FAIL both_rvalid cyc=%0d got=both want=one", cyc);
      end else if (bus.if_rvalid || bus.dm_rvalid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_rvalid cyc=%0d got=if%0d/dm%0d want=none", cyc, bus.if_rvalid, bus.dm_rvalid);
        end else begin
          e = q.pop_front();
          chk("rvalid_port", 32'(bus.dm_rvalid), 32'(e.port));
          chk("rvalid_cycle", 32'(cyc), 32'(e.due));
          if (e.port) begin
            chk("dm_rdata", bus.dm_rdata, e.data);
            last_dm = e.data;
          end else begin
            chk("if_rdata", bus.if_rdata, e.data);
            last_if = e.data;
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        total++; bad++;
        $display("FAIL missing_rvalid cyc=%0d got=none want=port%0d due=%0d", cyc, q[0].port, q[0].due);
        void'(q.pop_front());
      end
      chk("if_rdata_hold", bus.if_rdata, last_if);
      chk("dm_rdata_hold", bus.dm_rdata, last_dm);
      if (!rst && bus.if_req && !halted && !bus.if_gnt) if_wait++;
      else if_wait = 0;
      if (if_wait > 0) begin
        total++;
        if (if_wait > SM) begin
          bad++;
          $display("FAIL if_wait cyc=%0d got=%0d max=%0d", cyc, if_wait, SM);
        end
      end
    end
    if (rst) begin
      armed = 1'b1;
      q.delete();
      last_if = '0;
      last_dm = '0;
      if_wait = 0;
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(3))
      0:       return AW'(198);
      1:       return AW'(200);
      default: return AW'($urandom_range(15));
    endcase
  endfunction

  // One cycle of random requesters that hold each request until granted.
  task automatic step(input int p_if, input int p_dm, input int p_we, input int p_halt);
    logic gi, gd;
    @(negedge clk1);
    gi = bus.if_gnt;
    gd = bus.dm_gnt;
    @(posedge clk1); #1;
    if (!bus.if_req || gi) begin
      bus.if_req  = (int'($urandom_range(99)) < p_if);
      bus.if_addr = rand_addr();
    end
    if (!bus.dm_req || gd) begin
      bus.dm_req   = (int'($urandom_range(99)) < p_dm);
      bus.dm_we    = (int'($urandom_range(99)) < p_we);
      bus.dm_addr  = rand_addr();
      bus.dm_wdata = $urandom;
    end
    halted = (int'($urandom_range(99)) < p_halt);
  endtask

  task automatic hold(input int budget, input bit must_finish);
    logic gi, gd;
    int n;
    n = 0;
    while ((bus.if_req || bus.dm_req) && n < budget) begin
      @(negedge clk1);
      gi = bus.if_gnt;
      gd = bus.dm_gnt;
      @(posedge clk1); #1;
      if (gi) bus.if_req = 1'b0;
      if (gd) bus.dm_req = 1'b0;
      n++;
    end
    if (must_finish) begin
      total++;
      if (bus.if_req || bus.dm_req) begin
        bad++;
        $display("FAIL grant_timeout cyc=%0d got=if%0d/dm%0d pending want=none", cyc, bus.if_req, bus.dm_req);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk1);
    #1 rst = 1'b0;

    // Single fetch from word 0
    bus.if_req = 1'b1; bus.if_addr = '0;
    hold(8, 1'b1);
    idle(6);

    // Fetch and load collide: load wins, fetch follows
    bus.if_req = 1'b1; bus.if_addr = AW'(7);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = AW'(200);
    hold(8, 1'b1);
    idle(6);

    // Store then load of the same word in back-to-back cycles
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = AW'(198); bus.dm_wdata = 32'h15;
    hold(8, 1'b1);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = AW'(198);
    hold(8, 1'b1);
    idle(6);

    // Halt with a fetch in flight; loads keep flowing
    bus.if_req = 1'b1; bus.if_addr = AW'(3);
    hold(8, 1'b1);
    halted = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = AW'(4);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = AW'(9);
    hold(6, 1'b0);
    halted = 1'b0;
    hold(8, 1'b1);
    idle(6);

    // Both ports saturated: fetch must get through every STARVE_MAX+1 cycles
    repeat (30) step(100, 100, 30, 0);
    hold(10, 1'b1);
    idle(4);

    // Reset one cycle after a read grant, with a partial DM streak built up
    repeat (3) step(100, 100, 0, 0);
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
    repeat (12) step(100, 100, 0, 0);
    hold(10, 1'b1);
    idle(6);

    // Random mixed traffic
    repeat (800) step(60, 60, 40, 10);
    halted = 1'b0;
    hold(12, 1'b1);
    idle(LAT + 4);

    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
